serial_addsub_ctrl: RTL and testbench

- Bit-serial add/subtract unit built around one existing full_adder_1_bit.
- Sequences that adder over N cycles: LSB-first operand shift registers, a carry flip-flop and a bit counter.
- Start/done handshake; sits in the ALU as the low-area arithmetic path.
- Produces an N-bit result plus carry, signed-overflow and zero flags.

---
 rtl/alu_pkg.sv | 13 +
 rtl/full_adder_1_bit.sv | 13 +
 rtl/serial_addsub_ctrl.sv | 119 +++++++++++
 tb/tb_serial_addsub_ctrl.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: sequencer states and add/subtract opcode values.
package alu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/full_adder_1_bit.sv
// Single-bit full adder: the one arithmetic cell reused every cycle by the serial unit.
module full_adder_1_bit (
  input  logic a,
  input  logic b,
  input  logic c_in,
  output logic sum,
  output logic c_out
);

  assign sum   = a ^ b ^ c_in;
  assign c_out = (a & b) | (c_in & (a ^ b));

endmodule

// File: rtl/serial_addsub_ctrl.sv
// Bit-serial add/subtract unit. One full adder is stepped LSB-first over N
// cycles; subtraction is a + ~b + 1, with the +1 entering as the initial carry.
module serial_addsub_ctrl
  import alu_pkg::*;
#(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         op,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] result,
  output logic         c_out,
  output logic         overflow,
  output logic         zero
);

  localparam int CW = $clog2(N);

  state_t          state;
  state_t          state_nx;
  logic            accept;
  logic            last;
  logic [N-1:0]    sh_a;
  logic [N-1:0]    sh_b;
  logic [N-1:0]    res_sh;
  logic [N-1:0]    res_nx;
  logic            carry;
  logic [CW-1:0]   cnt;
  logic            fa_sum;
  logic            fa_cout;

  full_adder_1_bit u_fa (
    .a     (sh_a[0]),
    .b     (sh_b[0]),
    .c_in  (carry),
    .sum   (fa_sum),
    .c_out (fa_cout)
  );

  // The final bit is the one processed while the counter reads N-1.
  assign last   = (cnt == CW'(N - 1));
  assign res_nx = {fa_sum, res_sh[N-1:1]};

  // Status outputs are plain decodes of the registered state.
  assign busy = (state == RUN);
  assign done = (state == DONE);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state logic; start is honoured only in IDLE or DONE.
  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept   = 1'b1;
          state_nx = RUN;
        end
      end
      RUN: begin
        if (last) state_nx = DONE;
      end
      DONE: begin
        if (start) begin
          accept   = 1'b1;
          state_nx = RUN;
        end else begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Operand latching, serial shifting and final result/flag capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      sh_a     <= '0;
      sh_b     <= '0;
      res_sh   <= '0;
      carry    <= 1'b0;
      cnt      <= '0;
      result   <= '0;
      c_out    <= 1'b0;
      overflow <= 1'b0;
      zero     <= 1'b0;
    end else if (accept) begin
      sh_a   <= a;
      sh_b   <= (op == OP_SUB) ? ~b : b;
      carry  <= op;
      cnt    <= '0;
      res_sh <= '0;
    end else if (state == RUN) begin
      res_sh <= res_nx;
      sh_a   <= {1'b0, sh_a[N-1:1]};
      sh_b   <= {1'b0, sh_b[N-1:1]};
      carry  <= fa_cout;
      if (!last) cnt <= cnt + 1'b1;
      if (last) begin
        result   <= res_nx;
        c_out    <= fa_cout;
        // carry here is the carry into the MSB position.
        overflow <= carry ^ fa_cout;
        zero     <= (res_nx == '0);
      end
    end
  end

endmodule

// File: tb/tb_serial_addsub_ctrl.sv
// Bench for serial_addsub_ctrl with N=8: arithmetic reference model plus directed vectors.
module tb_serial_addsub_ctrl;

  localparam int N = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         op = 1'b0;
  logic [N-1:0] a = '0;
  logic [N-1:0] b = '0;
  logic         busy;
  logic         done;
  logic [N-1:0] result;
  logic         c_out;
  logic         overflow;
  logic         zero;

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_on = 1'b0;

  serial_addsub_ctrl #(.N(N)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .op       (op),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .c_out    (c_out),
    .overflow (overflow),
    .zero     (zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: remaining busy cycles plus the values the outputs must show.
  int           m_left = 0;
  bit           m_done = 1'b0;
  logic [N-1:0] m_res  = '0;
  bit           m_c    = 1'b0;
  bit           m_ov   = 1'b0;
  bit           m_z    = 1'b0;
  logic [N-1:0] p_res;
  bit           p_c, p_ov, p_z;

  // Whole-operation arithmetic evaluated when a start is accepted.
  always @(posedge clk) begin
    longint sa, sb, s, ua, ub;
    if (rst) begin
      m_left = 0; m_done = 0; m_res = '0; m_c = 0; m_ov = 0; m_z = 0;
    end else begin
      bit can_start;
      can_start = (m_left == 0);
      m_done = 0;
      if (m_left > 0) begin
        m_left--;
        if (m_left == 0) begin
          m_done = 1; m_res = p_res; m_c = p_c; m_ov = p_ov; m_z = p_z;
        end
      end
      if (can_start && start) begin
        ua = longint'(a); ub = longint'(b);
        sa = longint'($signed(a)); sb = longint'($signed(b));
        if (op) begin
          s     = sa - sb;
          p_res = N'(ua - ub);
          p_c   = (ua >= ub);
        end else begin
          s     = sa + sb;
          p_res = N'(ua + ub);
          p_c   = ((ua + ub) >= (longint'(1) << N));
        end
        p_ov   = (s > (longint'(1) << (N-1)) - 1) || (s < -(longint'(1) << (N-1)));
        p_z    = (p_res == '0);
        m_left = N;
      end
    end
  end

  // Cycle-by-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_on) begin
      chk("busy",     32'(busy),     32'(m_left > 0));
      chk("done",     32'(done),     32'(m_done));
      chk("result",   32'(result),   32'(m_res));
      chk("c_out",    32'(c_out),    32'(m_c));
      chk("overflow", 32'(overflow), 32'(m_ov));
      chk("zero",     32'(zero),     32'(m_z));
    end
  end

  // Drive a start at the current negedge.
  task automatic launch(input logic o, input logic [N-1:0] va, input logic [N-1:0] vb);
    start = 1'b1; op = o; a = va; b = vb;
  endtask

  // Wait for done; optionally inject an ignored start at cycle inj.
  task automatic wait_done(input int inj, output int lat, output int bcnt);
    lat = -1; bcnt = 0;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (i == 1) begin
        start = 1'b0; a = 8'hAA; b = 8'h55; op = ~op;
      end
      if (i == inj) begin
        start = 1'b1; op = 1'b0; a = 8'h11; b = 8'h22;
      end
      if (i == inj + 1) start = 1'b0;
      if (busy) bcnt++;
      if (done) begin
        lat = i;
        break;
      end
    end
    if (lat < 0) begin
      n_chk++; n_fail++;
      $display("FAIL done_timeout: no done within 30 cycles at %0t", $time);
    end
  endtask

  task automatic chk_out(input string tag, input logic [N-1:0] r, input bit c, input bit ov, input bit z);
    chk({tag, "_result"},   32'(result),   32'(r));
    chk({tag, "_c_out"},    32'(c_out),    32'(c));
    chk({tag, "_overflow"}, 32'(overflow), 32'(ov));
    chk({tag, "_zero"},     32'(zero),     32'(z));
  endtask

  initial begin
    int lat, bcnt, dones;
    // Reset held for two cycles.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_on = 1'b1;
    rst = 1'b0;
    chk_out("reset", 8'h00, 0, 0, 0);
    chk("reset_busy", 32'(busy), 32'd0);
    dones = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (done) dones++;
    end
    chk("idle_no_done", 32'(dones), 32'd0);

    // Signed overflow on add.
    launch(1'b0, 8'h7F, 8'h01);
    wait_done(0, lat, bcnt);
    chk("add1_latency", 32'(lat), 32'd9);
    chk("add1_busy_cycles", 32'(bcnt), 32'd8);
    chk_out("add1", 8'h80, 0, 1, 0);

    // Unsigned wrap to zero.
    @(negedge clk);
    launch(1'b0, 8'hFF, 8'h01);
    wait_done(0, lat, bcnt);
    chk_out("add2", 8'h00, 1, 0, 1);

    // Subtract with borrow.
    @(negedge clk);
    launch(1'b1, 8'h05, 8'h07);
    wait_done(0, lat, bcnt);
    chk_out("sub1", 8'hFE, 0, 0, 0);

    // Subtract with signed overflow, ignored mid-run start, back-to-back start in DONE.
    @(negedge clk);
    launch(1'b1, 8'h80, 8'h01);
    wait_done(4, lat, bcnt);
    chk("sub2_latency", 32'(lat), 32'd9);
    chk_out("sub2", 8'h7F, 1, 1, 0);
    launch(1'b0, 8'h10, 8'h20);
    wait_done(0, lat, bcnt);
    chk("b2b_latency", 32'(lat), 32'd9);
    chk_out("b2b", 8'h30, 0, 0, 0);

    // Reset during the fourth RUN cycle.
    @(negedge clk);
    launch(1'b0, 8'h0F, 8'h01);
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      if (i == 1) start = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_mid_busy", 32'(busy), 32'd0);
    chk_out("rst_mid", 8'h00, 0, 0, 0);
    dones = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done) dones++;
    end
    chk("rst_mid_no_done", 32'(dones), 32'd0);

    launch(1'b0, 8'h03, 8'h04);
    wait_done(0, lat, bcnt);
    chk_out("after_rst", 8'h07, 0, 0, 0);

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
